// File: rtl/fpdivide_iter.sv
// fpdivide_iter: multi-cycle floating-point divider (out = reg_A / reg_B).
//
// The mantissa quotient comes from a radix-2 restoring divider that produces
// one bit per cycle. Rounding is round-to-nearest-even. Subnormal inputs are
// flushed to signed zero, and no subnormal result is ever produced. Latency
// is constant: the special cases still run the full DIVIDE count, and their
// result replaces the arithmetic one in ROUND.
//
// Handshake: an operand pair transfers on a rising edge where
// in_valid && in_ready. in_ready is high only in IDLE. A result transfers on a
// rising edge where out_valid && out_ready. out and div_by_zero are held
// stable while out_valid is high and out_ready is low.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   in_valid     operands present on reg_A / reg_B
//   in_ready     divider can accept operands (IDLE only)
//   reg_A        dividend, W = 1+EXP_W+MAN_W bits
//   reg_B        divisor,  W bits
//   out_valid    result present on out
//   out_ready    consumer accepts result
//   out          quotient, W bits
//   div_by_zero  finite nonzero / zero; qualified by out_valid
module fpdivide_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] reg_A,
    input  logic [W-1:0] reg_B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         div_by_zero
);

    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EW   = EXP_W + 2;          // signed working exponent width
    localparam int QW   = MAN_W + 3;          // quotient bits: 1.frac + guard + 1
    localparam int CW   = $clog2(QW);
    localparam logic [CW-1:0]        LAST_BIT = CW'(QW - 1);
    localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE    = EW'(1);
    localparam logic signed [EW-1:0] E_BIAS   = EW'(BIAS);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
    state_t state, state_next;

    logic [W-1:0]           op_a, op_b;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_r;
    logic [MAN_W+1:0]       rem_r;            // partial remainder, < 2*divisor
    logic [MAN_W:0]         dvs_r;            // 1.mB
    logic [QW-1:0]          quo_r;
    logic [CW-1:0]          cnt_r;
    logic                   nan_r, inf_r, dbz_r, zero_r;

    // Operand field split and classification
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_max, b_max, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        ea     = op_a[W-2:MAN_W];
        eb     = op_b[W-2:MAN_W];
        fa     = op_a[MAN_W-1:0];
        fb     = op_b[MAN_W-1:0];
        a_max  = (ea == EXP_ONES);
        b_max  = (eb == EXP_ONES);
        a_zero = (ea == '0);                  // includes flushed subnormals
        b_zero = (eb == '0);
        a_inf  = a_max && (fa == '0);
        b_inf  = b_max && (fb == '0);
        a_nan  = a_max && (fa != '0);
        b_nan  = b_max && (fb != '0);
    end

    // One restoring step
    logic [MAN_W+1:0] dvs_ext, diff;
    logic             ge;

    always_comb begin
        dvs_ext = {1'b0, dvs_r};
        ge      = (rem_r >= dvs_ext);
        diff    = ge ? (rem_r - dvs_ext) : rem_r;
    end

    // Normalise, round, range-check and apply special-case overrides
    logic                 norm, guard, sticky, rup, carry;
    logic [MAN_W-1:0]     frac_pre;
    logic [MAN_W:0]       frac_sum;
    logic signed [EW-1:0] e_norm, e_fin;
    logic [W-1:0]         inf_word, result;
    logic                 res_dbz;

    always_comb begin
        norm     = quo_r[QW-1];               // 0 when mantissa ratio < 1
        frac_pre = norm ? quo_r[QW-2:2] : quo_r[QW-3:1];
        guard    = norm ? quo_r[1] : quo_r[0];
        sticky   = (norm & quo_r[0]) | (|rem_r);
        rup      = guard & (sticky | frac_pre[0]);
        frac_sum = {1'b0, frac_pre} + {{MAN_W{1'b0}}, rup};
        // Fraction overflow means the mantissa became 10.000..0, so the
        // fraction field is already zero and only the exponent moves.
        carry    = frac_sum[MAN_W];
        e_norm   = norm ? exp_r : (exp_r - E_ONE);
        e_fin    = e_norm + {{(EW-1){1'b0}}, carry};
        inf_word = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
        res_dbz  = 1'b0;
        if (nan_r) begin
            result = QNAN;
        end else if (inf_r) begin
            result = inf_word;
        end else if (dbz_r) begin
            result  = inf_word;
            res_dbz = 1'b1;
        end else if (zero_r) begin
            result = {sign_r, {(W-1){1'b0}}};
        end else if (e_fin >= E_MAX) begin
            result = inf_word;
        end else if (e_fin < E_ONE) begin
            result = {sign_r, {(W-1){1'b0}}};
        end else begin
            result = {sign_r, e_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        end
    end

    // FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = UNPACK;
            UNPACK:  state_next = DIVIDE;
            DIVIDE:  if (cnt_r == LAST_BIT) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a        <= '0;
            op_b        <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            rem_r       <= '0;
            dvs_r       <= '0;
            quo_r       <= '0;
            cnt_r       <= '0;
            nan_r       <= 1'b0;
            inf_r       <= 1'b0;
            dbz_r       <= 1'b0;
            zero_r      <= 1'b0;
            out         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= reg_A;
                        op_b <= reg_B;
                    end
                end
                UNPACK: begin
                    sign_r <= op_a[W-1] ^ op_b[W-1];
                    exp_r  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
                    rem_r  <= {1'b0, 1'b1, fa};
                    dvs_r  <= {1'b1, fb};
                    quo_r  <= '0;
                    cnt_r  <= '0;
                    nan_r  <= a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
                    inf_r  <= a_inf;
                    dbz_r  <= b_zero & ~a_zero & ~a_max;
                    zero_r <= a_zero | b_inf;
                end
                DIVIDE: begin
                    rem_r <= diff << 1;
                    quo_r <= {quo_r[QW-2:0], ge};
                    cnt_r <= cnt_r + 1'b1;
                end
                ROUND: begin
                    out         <= result;
                    div_by_zero <= res_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdivide_iter.sv
// Directed bench for fpdivide_iter: single precision (8/23) and half
// precision (5/10) instances sharing one clock and reset.
module tb_fpdivide_iter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, ordy32, dbz32;
    logic [31:0] a32, b32, o32;
    logic        iv16, ir16, ov16, ordy16, dbz16;
    logic [15:0] a16, b16, o16;

    fpdivide_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .reg_A(a32), .reg_B(b32), .out_valid(ov32), .out_ready(ordy32),
        .out(o32), .div_by_zero(dbz32)
    );

    fpdivide_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .reg_A(a16), .reg_B(b16), .out_valid(ov16), .out_ready(ordy16),
        .out(o16), .div_by_zero(dbz16)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    logic watch = 1'b0;
    logic spurious = 1'b0;
    always @(negedge clk) if (watch && ov32) spurious <= 1'b1;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic cur_ir(input bit half);
        return half ? ir16 : ir32;
    endfunction
    function automatic logic cur_ov(input bit half);
        return half ? ov16 : ov32;
    endfunction
    function automatic logic cur_dbz(input bit half);
        return half ? dbz16 : dbz32;
    endfunction
    function automatic logic [31:0] cur_out(input bit half);
        return half ? {16'h0000, o16} : o32;
    endfunction

    // One full transaction with out_ready held high.
    task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic exp_dbz,
                          input int exp_lat, input string tag);
        int n;
        logic [31:0] e;
        n = 0;
        @(negedge clk);
        while (!cur_ir(half) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, 32'(cur_ir(half)), 32'd1);
        if (half) begin
            a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1; ordy16 = 1'b1;
        end else begin
            a32 = a; b32 = b; iv32 = 1'b1; ordy32 = 1'b1;
        end
        exp_q.push_back(exp_out);
        @(posedge clk); #1;
        iv16 = 1'b0;
        iv32 = 1'b0;
        // Busy operands must be ignored
        a32 = $urandom; b32 = $urandom;
        a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (!cur_ov(half) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        e = exp_q.pop_front();
        check({tag, " out"}, cur_out(half), e);
        check({tag, " dbz"}, 32'(cur_dbz(half)), 32'(exp_dbz));
        @(posedge clk); #1;
        check({tag, " release"}, 32'(cur_ov(half)), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        iv32 = 1'b0; ordy32 = 1'b0; a32 = '0; b32 = '0;
        iv16 = 1'b0; ordy16 = 1'b0; a16 = '0; b16 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready32", 32'(ir32), 32'd1);
        check("rst out_valid32", 32'(ov32), 32'd0);
        check("rst out32", o32, 32'h0);
        check("rst dbz32", 32'(dbz32), 32'd0);
        check("rst in_ready16", 32'(ir16), 32'd1);
        check("rst out_valid16", 32'(ov16), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic arithmetic
        run_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, "6div2");
        run_op(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28, "1div3");
        run_op(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 28, "1div1");

        // Special cases
        run_op(0, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 28, "pos_div0");
        run_op(0, 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 28, "neg_div0");
        run_op(0, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 28, "0div0");
        run_op(0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 28, "infdivinf");
        run_op(0, 32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 28, "xdivinf");
        run_op(0, 32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0, 28, "negxdivinf");
        run_op(0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 28, "nan_in");
        run_op(0, 32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 28, "infdivx");

        // Range limits
        run_op(0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 28, "overflow");
        run_op(0, 32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 28, "underflow");
        run_op(0, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 28, "subnormal");

        // Backpressure
        @(negedge clk);
        a32 = 32'h40C00000; b32 = 32'h40000000; iv32 = 1'b1; ordy32 = 1'b0;
        @(posedge clk); #1;
        iv32 = 1'b0;
        n = 0;
        while (!ov32 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", 32'(n), 32'd28);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid held", 32'(ov32), 32'd1);
            check("bp out held", o32, 32'h40400000);
            check("bp in_ready low", 32'(ir32), 32'd0);
        end
        @(negedge clk);
        ordy32 = 1'b1;
        check("bp in_ready at handshake", 32'(ir32), 32'd0);
        @(posedge clk); #1;
        check("bp out_valid drop", 32'(ov32), 32'd0);
        check("bp in_ready back", 32'(ir32), 32'd1);

        // Back-to-back
        run_op(0, 32'h40800000, 32'h40000000, 32'h40000000, 1'b0, 28, "b2b_a");
        run_op(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28, "b2b_b");

        // Reset in the middle of DIVIDE
        @(negedge clk);
        a32 = 32'h3F800000; b32 = 32'h40400000; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        watch = 1'b1;
        repeat (11) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst out_valid", 32'(ov32), 32'd0);
        check("mid_rst out", o32, 32'h0);
        check("mid_rst in_ready", 32'(ir32), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        watch = 1'b0;
        check("mid_rst no result", 32'(spurious), 32'd0);
        run_op(0, 32'h40800000, 32'h40000000, 32'h40000000, 1'b0, 28, "after_rst");

        // Half precision
        run_op(1, 32'h00003C00, 32'h00004000, 32'h00003800, 1'b0, 15, "h_1div2");
        run_op(1, 32'h00003C00, 32'h00000000, 32'h00007C00, 1'b1, 15, "h_div0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpdivide_iter.md
Name: fpdivide_iter

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point divider. It is the next generation of the single-precision fpdivide_system.
- Computes reg_A / reg_B with a radix-2 restoring mantissa divider, so one large combinational divider is not needed.
- Adds a valid/ready handshake on input and output, round-to-nearest-even, full special-case handling and a divide-by-zero flag.
- Sits between the operand register file and the result writeback in the FPU.

Parameters:
EXP_W, 8, exponent field width.
MAN_W, 23, stored fraction width; total word width W = 1+EXP_W+MAN_W.
BIAS is derived as 2^(EXP_W-1)-1 and is not overridable.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  operands present on reg_A/reg_B.
in_ready  out  1  divider can accept operands.
reg_A  in  W  dividend.
reg_B  in  W  divisor.
out_valid  out  1  result present on out.
out_ready  in  1  consumer accepts result.
out  out  W  quotient.
div_by_zero  out  1  qualified by out_valid; finite nonzero / zero.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: out=0, out_valid=0, div_by_zero=0, in_ready=1.
  - State returns to IDLE.
  - An operation in flight is discarded, with no output.
- Accept: in_valid & in_ready at a rising edge latches reg_A/reg_B. in_ready is 1 only in IDLE.
- FSM states and transitions:
  - IDLE: on accept, go to UNPACK.
  - UNPACK: 1 cycle. Split fields; classify zero/inf/NaN. Subnormal inputs are flushed to signed zero. Form sign = sA^sB and exponent e = eA-eB+BIAS (signed, EXP_W+2 bits). Load 1.mA and 1.mB.
  - DIVIDE: MAN_W+3 cycles, one quotient bit per cycle, restoring subtract and shift. A counter runs from 0 to MAN_W+2, then go to ROUND.
  - ROUND: 1 cycle.
    - If quotient MSB=0 (mantissa ratio <1), shift left 1 and decrement e.
    - Guard = next bit; sticky = OR of the remaining bits and (remainder != 0).
    - Round to nearest even. A mantissa carry-out increments e.
    - e >= 2^EXP_W-1 gives signed inf. e <= 0 gives signed zero (flush, no subnormal outputs).
    - Then go to DONE.
  - DONE: out_valid=1; out and div_by_zero are held stable until out_ready=1. On that edge, out_valid drops and the FSM returns to IDLE. in_ready becomes 1 on the following cycle; there is no same-cycle re-accept.
- Latency: out_valid rises exactly MAN_W+5 cycles after the accept edge (28 for the defaults), for all operands. Special cases still run the full DIVIDE count and override the result in ROUND (constant latency).
- Special-case results (override, highest priority first):
  - Any NaN, 0/0, or inf/inf: canonical qNaN = sign 0, exponent all ones, fraction MSB 1 and other bits 0.
  - inf/x: signed inf.
  - finite nonzero/0: signed inf and div_by_zero=1.
  - x/inf or 0/x: signed zero.
- div_by_zero is 0 for every case other than finite nonzero/0.
- Inputs changing while busy are ignored.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. Basic, defaults: 40C00000 / 40000000 with out_ready=1 -> out=40400000, out_valid high exactly 28 cycles after accept, div_by_zero=0. Then 3F800000/40400000 -> 3EAAAAAB (round-up case).
2. Specials:
   - 3F800000/00000000 -> 7F800000, div_by_zero=1.
   - BF800000/00000000 -> FF800000, div_by_zero=1.
   - 00000000/00000000 -> 7FC00000.
   - 7F800000/7F800000 -> 7FC00000.
   - 40000000/7F800000 -> 00000000.
   - 7FC00001/3F800000 -> 7FC00000.
3. Range limits:
   - 7F7FFFFF/3F000000 -> 7F800000.
   - 00800000/40000000 -> 00000000 (flush).
   - subnormal 00000001/3F800000 -> 00000000.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out/out_valid stable and in_ready=0 throughout. Assert out_ready -> out_valid falls next edge, in_ready=1 one cycle later. Back-to-back operations are accepted with no loss.
5. Reset mid-operation: assert reset 10 cycles into a DIVIDE -> out_valid=0, out=0, in_ready=1 immediately, with no result emitted. The next operation 40800000/40000000 -> 40000000 with full latency.
6. Half precision, EXP_W=5, MAN_W=10: 3C00/4000 -> 3800, latency 15. Also 3C00/0000 -> 7C00 with div_by_zero=1.
